// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one single-port memory.
// Define MEM_ARB_RR_EN for round-robin instead of data-first priority.
module mem_port_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int TIMEOUT   = 16,
  parameter logic [WORD_SIZE-1:0] ERR_DATA = 32'h0000_0013
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_IfReq,
  input  logic [WORD_SIZE-1:0] i_IfAddr,
  output logic                 o_IfGnt,
  output logic                 o_IfRvalid,
  output logic [WORD_SIZE-1:0] o_IfRdata,
  input  logic                 i_DmReq,
  input  logic                 i_DmWen,
  input  logic [WORD_SIZE-1:0] i_DmAddr,
  input  logic [WORD_SIZE-1:0] i_DmWdata,
  output logic                 o_DmGnt,
  output logic                 o_DmRvalid,
  output logic [WORD_SIZE-1:0] o_DmRdata,
  output logic                 o_MemReq,
  output logic                 o_MemWen,
  output logic [WORD_SIZE-1:0] o_MemAddr,
  output logic [WORD_SIZE-1:0] o_MemWdata,
  input  logic                 i_MemGnt,
  input  logic                 i_MemRvalid,
  input  logic [WORD_SIZE-1:0] i_MemRdata,
  output logic                 o_Err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [7:0]           cnt_q;
  logic [WORD_SIZE-1:0] addr_q, wdata_q;
  logic                 wen_q, own_dm_q;
  logic                 if_rv_q, dm_rv_q, err_q;
  logic [WORD_SIZE-1:0] if_rd_q, dm_rd_q;
  logic                 pick_dm, gnt_any;
  logic                 wr_done, rd_done, tmo;

`ifdef MEM_ARB_RR_EN
  logic last_dm_q;
  // both requesting: the side not served last wins
  assign pick_dm = i_DmReq & (~i_IfReq | ~last_dm_q);
`else
  assign pick_dm = i_DmReq;
`endif

  assign gnt_any = (state_q == S_IDLE) & ~i_rst
                 & (i_IfReq | i_DmReq);
  assign o_DmGnt = gnt_any & pick_dm;
  assign o_IfGnt = gnt_any & ~pick_dm;

  assign wr_done = (state_q == S_ISSUE) & i_MemGnt & wen_q;
  assign rd_done = (state_q == S_WAIT) & i_MemRvalid;
  assign tmo     = (state_q == S_WAIT) & ~i_MemRvalid
                 & (cnt_q == TMO_LAST);

  assign o_MemReq   = (state_q == S_ISSUE);
  assign o_MemWen   = o_MemReq & wen_q;
  assign o_MemAddr  = o_MemReq ? addr_q : '0;
  assign o_MemWdata = o_MemReq ? wdata_q : '0;
  assign o_IfRvalid = if_rv_q;
  assign o_IfRdata  = if_rd_q;
  assign o_DmRvalid = dm_rv_q;
  assign o_DmRdata  = dm_rd_q;
  assign o_Err      = err_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (gnt_any) state_d = S_ISSUE;
      S_ISSUE: if (i_MemGnt)
                 state_d = wen_q ? S_IDLE : S_WAIT;
      S_WAIT:  if (rd_done | tmo) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      own_dm_q <= 1'b0;
      if_rv_q  <= 1'b0;
      dm_rv_q  <= 1'b0;
      if_rd_q  <= '0;
      dm_rd_q  <= '0;
      err_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_dm_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if_rv_q <= 1'b0;
      dm_rv_q <= 1'b0;
      err_q   <= tmo;
      if (gnt_any) begin
        addr_q   <= pick_dm ? i_DmAddr : i_IfAddr;
        wen_q    <= pick_dm & i_DmWen;
        wdata_q  <= pick_dm ? i_DmWdata : '0;
        own_dm_q <= pick_dm;
`ifdef MEM_ARB_RR_EN
        last_dm_q <= pick_dm;
`endif
      end
      if ((state_q == S_ISSUE) & i_MemGnt)
        cnt_q <= '0;
      else if (state_q == S_WAIT)
        cnt_q <= cnt_q + 8'd1;
      if (wr_done) begin
        dm_rv_q <= 1'b1;
        dm_rd_q <= '0;
      end
      // real data beats the timeout on the same cycle
      if (rd_done | tmo) begin
        if (own_dm_q) begin
          dm_rv_q <= 1'b1;
          dm_rd_q <= rd_done ? i_MemRdata : ERR_DATA;
        end else begin
          if_rv_q <= 1'b1;
          if_rd_q <= rd_done ? i_MemRdata : ERR_DATA;
        end
      end
    end
  end

endmodule
